// File: rtl/dcm_reset_sequencer.sv
// DCM lock-side controller: pulses DCM RST, retries on lock timeout, releases sys_reset after stable lock.
// Optional macro DCM_RESET_SEQUENCER_SYNC_EN adds a 2-flop synchronizer on dcm_locked.
module dcm_reset_sequencer #(
    parameter int ResetHold    = 4,
    parameter int LockTimeout  = 65535,
    parameter int SettleCycles = 16,
    parameter int RetryMax     = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dcm_locked,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retries,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [15:0] HoldLast    = 16'(ResetHold - 1);
    localparam logic [15:0] TimeoutLast = 16'(LockTimeout - 1);
    localparam logic [15:0] SettleLast  = 16'(SettleCycles - 1);
    localparam logic [2:0]  RetryLast   = 3'(RetryMax);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  retries_nxt;
    logic        lk;

`ifdef DCM_RESET_SEQUENCER_SYNC_EN
    logic lk_meta, lk_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            lk_meta <= 1'b0;
            lk_sync <= 1'b0;
        end else begin
            lk_meta <= dcm_locked;
            lk_sync <= lk_meta;
        end
    end

    assign lk = lk_sync;
`else
    assign lk = dcm_locked;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            retries <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            retries <= retries_nxt;
        end
    end

    // Lock is checked before the timeout so a lock arriving on the timeout cycle wins.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 16'd1;
        retries_nxt = retries;
        case (state)
            ST_HOLD: begin
                if (cnt == HoldLast) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (lk) begin
                    state_nxt = ST_SETTLE;
                end else if (cnt == TimeoutLast) begin
                    if (retries == RetryLast) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        retries_nxt = retries + 3'd1;
                        state_nxt   = ST_HOLD;
                    end
                end
            end
            ST_SETTLE: begin
                if (!lk) begin
                    state_nxt = ST_WAIT;
                end else if (cnt == SettleLast) begin
                    state_nxt   = ST_RUN;
                    retries_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!lk) state_nxt = ST_HOLD;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            dcm_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            dcm_reset <= (state == ST_HOLD) || (state == ST_FAULT);
            sys_reset <= (state != ST_RUN);
            ready     <= (state == ST_RUN);
            fault     <= (state == ST_FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Self-checking bench for dcm_reset_sequencer: directed scenarios plus random lock traffic
// checked against a deadline-based reference model.
module tb_dcm_reset_sequencer;

    localparam int RH  = 4;
    localparam int LT  = 100;
    localparam int S   = 16;
    localparam int RM  = 2;
`ifdef DCM_RESET_SEQUENCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [6:0] RESET_VEC = 7'b1100000;

    logic       clock;
    logic       reset;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [2:0] retries;
    logic [2:0] state_dbg;

    int n_vec;
    int n_bad;

    dcm_reset_sequencer #(
        .ResetHold   (RH),
        .LockTimeout (LT),
        .SettleCycles(S),
        .RetryMax    (RM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .dcm_locked(dcm_locked),
        .dcm_reset (dcm_reset),
        .sys_reset (sys_reset),
        .ready     (ready),
        .fault     (fault),
        .retries   (retries),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: phases with absolute entry times; outputs trail the phase by one edge
    localparam int P_HOLD = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAULT = 4;
    int         m_phase;
    int         m_enter;
    int         m_tries;
    int         m_t;
    logic       m_pipe[$];
    logic [6:0] exp_q[$];

    task automatic model_tick(input logic rst, input logic lock);
        logic       lk;
        logic [3:0] flags;
        m_t++;
        if (rst) begin
            m_phase = P_HOLD;
            m_enter = m_t;
            m_tries = 0;
            m_pipe.delete();
            for (int i = 0; i < LAT; i++) m_pipe.push_back(1'b0);
            exp_q.push_back(RESET_VEC);
            return;
        end
        flags = {(m_phase == P_HOLD) || (m_phase == P_FAULT), m_phase != P_RUN,
                 m_phase == P_RUN, m_phase == P_FAULT};
        m_pipe.push_back(lock);
        lk = m_pipe.pop_front();
        case (m_phase)
            P_HOLD:   if (m_t - m_enter == RH) begin m_phase = P_WAIT; m_enter = m_t; end
            P_WAIT: begin
                if (lk) begin
                    m_phase = P_SETTLE; m_enter = m_t;
                end else if (m_t - m_enter == LT) begin
                    if (m_tries == RM) m_phase = P_FAULT;
                    else begin m_tries++; m_phase = P_HOLD; end
                    m_enter = m_t;
                end
            end
            P_SETTLE: begin
                if (!lk) begin
                    m_phase = P_WAIT; m_enter = m_t;
                end else if (m_t - m_enter == S) begin
                    m_phase = P_RUN; m_enter = m_t; m_tries = 0;
                end
            end
            P_RUN:    if (!lk) begin m_phase = P_HOLD; m_enter = m_t; end
            default:  ;
        endcase
        exp_q.push_back({flags, 3'(m_tries)});
    endtask

    // driver tasks
    task automatic step(input logic lock, input logic rst);
        dcm_locked = lock;
        reset      = rst;
        @(posedge clock);
        model_tick(rst, lock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        logic [6:0] discard;
        step(1'b0, 1'b1);
        discard = exp_q.pop_front();
    endtask

    function automatic logic [6:0] dut_vec();
        return {dcm_reset, sys_reset, ready, fault, retries};
    endfunction

    task automatic test_reset();
        logic [6:0] exp;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b1);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL reset_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            n_vec++;
            if (dut_vec() !== RESET_VEC) begin
                n_bad++; $display("FAIL reset_values c=%0d got=%b want=%b", c, dut_vec(), RESET_VEC);
            end
        end
    endtask

    task automatic test_lock();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 40 + LAT; c++) begin
            step(1'(c >= 10), 1'b0);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL lock_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            n_vec++;
            if (dcm_reset !== 1'(c < RH)) begin
                n_bad++; $display("FAIL lock_dcm_reset c=%0d got=%b want=%b", c, dcm_reset, c < RH);
            end
            n_vec++;
            if (ready !== 1'(c >= 10 + S + 1 + LAT) || sys_reset !== 1'(c < 10 + S + 1 + LAT)) begin
                n_bad++; $display("FAIL lock_release c=%0d got ready=%b sys=%b want ready=%b", c, ready,
                                  sys_reset, c >= 10 + S + 1 + LAT);
            end
            n_vec++;
            if (retries !== 3'd0) begin
                n_bad++; $display("FAIL lock_retries c=%0d got=%0d want=0", c, retries);
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] exp;
        logic       want_dcm;
        logic [2:0] want_ret;
        do_reset();
        for (int c = 0; c < 330; c++) begin
            step(1'b0, 1'b0);
            exp = exp_q.pop_front();
            want_dcm = (c >= (RM + 1) * (RH + LT)) ? 1'b1 : 1'((c % (RH + LT)) < RH);
            want_ret = (c < RH + LT - 1) ? 3'd0 : (c < 2 * (RH + LT) - 1) ? 3'd1 : 3'd2;
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL timeout_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            n_vec++;
            if (dcm_reset !== want_dcm || retries !== want_ret) begin
                n_bad++; $display("FAIL timeout_pulse c=%0d got dcm=%b ret=%0d want dcm=%b ret=%0d", c,
                                  dcm_reset, retries, want_dcm, want_ret);
            end
            n_vec++;
            if (fault !== 1'(c >= (RM + 1) * (RH + LT))) begin
                n_bad++; $display("FAIL timeout_fault c=%0d got=%b want=%b", c, fault,
                                  c >= (RM + 1) * (RH + LT));
            end
        end
    endtask

    task automatic test_fault_reset();
        logic [6:0] exp;
        step(1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (dut_vec() !== RESET_VEC || exp !== RESET_VEC) begin
            n_bad++; $display("FAIL fault_reset got=%b want=%b", dut_vec(), RESET_VEC);
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b0);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL fault_restart c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_run_drop();
        logic [6:0] exp;
        int         pulses;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 60 + LAT; c++) begin
            step(1'(c != 30), 1'b0);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL drop_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            if (c > 30 + LAT && dcm_reset === 1'b1) pulses++;
            if (c == 30 + LAT) begin
                n_vec++;
                if (ready !== 1'b1) begin
                    n_bad++; $display("FAIL drop_before c=%0d got ready=%b want=1", c, ready);
                end
            end
            if (c == 31 + LAT) begin
                n_vec++;
                if ({sys_reset, ready, dcm_reset} !== 3'b101) begin
                    n_bad++; $display("FAIL drop_after c=%0d got=%b want=101", c, {sys_reset, ready, dcm_reset});
                end
            end
            if (c == 51 + LAT || c == 52 + LAT) begin
                n_vec++;
                if (ready !== 1'(c == 52 + LAT)) begin
                    n_bad++; $display("FAIL drop_resettle c=%0d got ready=%b want=%b", c, ready, c == 52 + LAT);
                end
            end
        end
        n_vec++;
        if (pulses !== RH) begin
            n_bad++; $display("FAIL drop_pulse_width got=%0d want=%0d", pulses, RH);
        end
    endtask

    task automatic test_settle_glitch();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 160 + LAT; c++) begin
            step(1'(c >= 120 && c != 129), 1'b0);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL glitch_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            if (c == 130 + LAT) begin
                n_vec++;
                if (retries !== 3'd1 || dcm_reset !== 1'b0) begin
                    n_bad++; $display("FAIL glitch_rewait c=%0d got ret=%0d dcm=%b want ret=1 dcm=0", c,
                                      retries, dcm_reset);
                end
            end
            if (c == 146 + LAT || c == 147 + LAT) begin
                n_vec++;
                if (ready !== 1'(c == 147 + LAT) || sys_reset !== 1'(c == 146 + LAT)) begin
                    n_bad++; $display("FAIL glitch_release c=%0d got ready=%b sys=%b want ready=%b", c,
                                      ready, sys_reset, c == 147 + LAT);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'(c == 30));
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL midrun_model c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
            if (c == 29 || c == 30) begin
                n_vec++;
                if (dut_vec() !== ((c == 30) ? RESET_VEC : 7'b0010000)) begin
                    n_bad++; $display("FAIL midrun_reset c=%0d got=%b want=%b", c, dut_vec(),
                                      (c == 30) ? RESET_VEC : 7'b0010000);
                end
            end
            if (c == 30 + RH || c == 31 + RH) begin
                n_vec++;
                if (dcm_reset !== 1'(c == 30 + RH)) begin
                    n_bad++; $display("FAIL midrun_hold c=%0d got=%b want=%b", c, dcm_reset, c == 30 + RH);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        logic       lvl;
        logic       rst;
        int         seg_left;
        seg_left = 0;
        lvl      = 1'b0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (seg_left == 0) begin
                lvl      = 1'($urandom_range(0, 3) != 0);
                seg_left = lvl ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 130));
            end
            seg_left--;
            rst = 1'($urandom_range(0, 299) == 0);
            step(lvl, rst);
            exp = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== exp) begin
                n_bad++; $display("FAIL random c=%0d got=%b want=%b", c, dut_vec(), exp);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        dcm_locked = 1'b0;
        n_vec      = 0;
        n_bad      = 0;
        m_t        = 0;
        m_phase    = P_HOLD;
        m_enter    = 0;
        m_tries    = 0;
        test_reset();
        test_lock();
        test_timeout();
        test_fault_reset();
        test_run_drop();
        test_settle_glitch();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
